// File: rtl/maj_fold_sched.sv
// rtl/maj_fold_sched.sv - folded majority sequencer: CHUNK-wide popcount-accumulate over an N-bit vote vector
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   vote vector available
//   in_ready   out  block can accept a vector (IDLE)
//   in_x       in   N-bit vote vector
//   out_valid  out  result available (DONE)
//   out_ready  in   consumer takes the result
//   out_y      out  majority decision (popcount >= THRESH)
//   out_count  out  accumulated popcount
//   busy       out  ACCUM or DONE
//
// Optional feature: MAJ_FOLD_EARLY_EXIT_EN stops accumulating as soon as the
// decision can no longer change.

module maj_fold_sched #(
   parameter int N      = 27,
   parameter int CHUNK  = 9,
   parameter int THRESH = (N + 1) / 2,
   parameter int NCH    = (N + CHUNK - 1) / CHUNK,
   parameter int CW     = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_x,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_y,
   output logic [CW-1:0] out_count,
   output logic          busy
);

   localparam int W  = NCH * CHUNK;
   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [CW-1:0] THR    = CW'(THRESH);
   localparam logic [CW-1:0] LAST_I = CW'(NCH - 1);

   logic [1:0]    state_q, state_d;
   logic [W-1:0]  sh_q, sh_d;
   logic [CW-1:0] acc_q, acc_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          y_q, y_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [CW-1:0] chunk_pop;
   logic [CW-1:0] acc_sum;
   logic          last_chunk;
   logic          finish;

`ifdef MAJ_FOLD_EARLY_EXIT_EN
   // Count of real vote bits not yet consumed; padding never counts.
   logic [CW-1:0] rem_q, rem_d;
   logic [CW-1:0] rem_nxt;
   logic [CW:0]   reach;
`endif

   // Current chunk always sits in the low CHUNK bits of the shift register.
   always_comb begin
      chunk_pop = '0;
      for (int i = 0; i < CHUNK; i++) begin
         chunk_pop = chunk_pop + CW'(sh_q[i]);
      end
   end

   assign acc_sum    = acc_q + chunk_pop;
   assign last_chunk = (CW'(idx_q) == LAST_I);

`ifdef MAJ_FOLD_EARLY_EXIT_EN
   assign rem_nxt = (rem_q > CW'(CHUNK)) ? (rem_q - CW'(CHUNK)) : '0;
   assign reach   = {1'b0, acc_sum} + {1'b0, rem_nxt};
   // Stop once the decision is fixed: threshold already met, or unreachable.
   assign finish  = last_chunk || (acc_sum >= THR) || (reach < (CW + 1)'(THRESH));
`else
   assign finish  = last_chunk;
`endif

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      y_d     = y_q;
      cnt_d   = cnt_q;
`ifdef MAJ_FOLD_EARLY_EXIT_EN
      rem_d   = rem_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               sh_d    = W'(in_x);
               acc_d   = '0;
               idx_d   = '0;
`ifdef MAJ_FOLD_EARLY_EXIT_EN
               rem_d   = CW'(N);
`endif
               state_d = S_ACCUM;
            end
         end
         S_ACCUM: begin
            acc_d = acc_sum;
            idx_d = idx_q + 1'b1;
            sh_d  = sh_q >> CHUNK;
`ifdef MAJ_FOLD_EARLY_EXIT_EN
            rem_d = rem_nxt;
`endif
            if (finish) begin
               y_d     = (acc_sum >= THR);
               cnt_d   = acc_sum;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         sh_q    <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
         y_q     <= 1'b0;
         cnt_q   <= '0;
`ifdef MAJ_FOLD_EARLY_EXIT_EN
         rem_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         y_q     <= y_d;
         cnt_q   <= cnt_d;
`ifdef MAJ_FOLD_EARLY_EXIT_EN
         rem_q   <= rem_d;
`endif
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q == S_ACCUM) || (state_q == S_DONE);
   assign out_y     = y_q;
   assign out_count = cnt_q;

endmodule

// File: tb/tb_maj_fold_sched.sv
// tb/tb_maj_fold_sched.sv - self-checking bench for maj_fold_sched

module tb_maj_fold_sched;

   localparam int N      = 27;
   localparam int CHUNK  = 9;
   localparam int THRESH = 14;
   localparam int NCH    = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [26:0] in_x;
   logic        out_valid;
   logic        out_ready;
   logic        out_y;
   logic [4:0]  out_count;
   logic        busy;

   int checks = 0;
   int errors = 0;

   maj_fold_sched dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .out_count (out_count),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [26:0] x;
      logic        y;
      logic [4:0]  cnt;
      int          lat;
   } vec_t;

   vec_t tbl[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: decision rules applied chunk by chunk with plain integers.
   task automatic model(input logic [26:0] x, output logic y, output logic [4:0] c, output int lat);
      int acc;
      int rem;
      logic [26:0] t;
      acc = 0;
      lat = NCH;
      for (int k = 0; k < NCH; k++) begin
         t   = x >> (k * CHUNK);
         acc = acc + $countones(t[CHUNK-1:0]);
         rem = N - (((k + 1) * CHUNK > N) ? N : (k + 1) * CHUNK);
`ifdef MAJ_FOLD_EARLY_EXIT_EN
         if (acc >= THRESH || acc + rem < THRESH) begin
            lat = k + 1;
            break;
         end
`endif
      end
      y = (acc >= THRESH);
      c = 5'(acc);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_out_y"},     32'(out_y),     32'd0);
      chk({tag, "_out_count"}, 32'(out_count), 32'd0);
      chk({tag, "_busy"},      32'(busy),      32'd0);
   endtask

   // Entered and left at #1 after a rising edge.
   task automatic run_txn(input logic [26:0] x, input logic ey, input logic [4:0] ec,
                          input int elat, input int gap, input int bp, input bit noise);
      int lat;
      logic y0;
      logic [4:0] c0;
      for (int g = 0; g < gap; g++) begin
         @(posedge clk); #1;
      end
      chk("idle_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_x     = x;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         if (noise) begin
            chk("accum_in_ready", 32'(in_ready), 32'd0);
            chk("accum_busy", 32'(busy), 32'd1);
            in_valid = 1'($urandom_range(0, 1));
            in_x     = 27'($urandom);
         end
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", 32'(lat), 32'(elat));
      chk("out_y", 32'(out_y), 32'(ey));
      chk("out_count", 32'(out_count), 32'(ec));
      y0 = out_y;
      c0 = out_count;
      for (int b = 0; b < bp; b++) begin
         in_valid = 1'b1;
         in_x     = 27'($urandom);
         @(posedge clk); #1;
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_busy", 32'(busy), 32'd1);
         chk("bp_out_y", 32'(out_y), 32'(y0));
         chk("bp_out_count", 32'(out_count), 32'(c0));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("release_out_valid", 32'(out_valid), 32'd0);
      chk("release_in_ready", 32'(in_ready), 32'd1);
      chk("release_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      logic       my;
      logic [4:0] mc;
      int         ml;
      logic [26:0] rx;

`ifdef MAJ_FOLD_EARLY_EXIT_EN
      tbl[0] = '{27'h0000000, 1'b0, 5'd0,  2};
      tbl[1] = '{27'h7FFFFFF, 1'b1, 5'd18, 2};
      tbl[2] = '{27'h0003FFF, 1'b1, 5'd14, 2};
      tbl[3] = '{27'h0001FFF, 1'b0, 5'd13, 3};
      tbl[4] = '{27'h7FC0000, 1'b0, 5'd0,  2};
`else
      tbl[0] = '{27'h0000000, 1'b0, 5'd0,  3};
      tbl[1] = '{27'h7FFFFFF, 1'b1, 5'd27, 3};
      tbl[2] = '{27'h0003FFF, 1'b1, 5'd14, 3};
      tbl[3] = '{27'h0001FFF, 1'b0, 5'd13, 3};
      tbl[4] = '{27'h7FC0000, 1'b0, 5'd9,  3};
`endif

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_x      = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 5; i++) begin
         run_txn(tbl[i].x, tbl[i].y, tbl[i].cnt, tbl[i].lat, i % 2, 0, 1'b1);
      end

      // Backpressure: five stalled cycles in DONE with in_valid pushing.
      run_txn(27'h7FFFFFF, tbl[1].y, tbl[1].cnt, tbl[1].lat, 0, 5, 1'b0);

      // Reset sampled at the second ACCUM edge.
      in_valid = 1'b1;
      in_x     = 27'h7FFFFFF;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_reset_outputs("midreset");
      run_txn(tbl[2].x, tbl[2].y, tbl[2].cnt, tbl[2].lat, 0, 0, 1'b0);

      // Reset while held in DONE.
      in_valid = 1'b1;
      in_x     = 27'h0003FFF;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("pre_done_reset_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_reset_outputs("donereset");

      for (int i = 0; i < 6000; i++) begin
         case ($urandom_range(0, 3))
            0: rx = 27'($urandom);
            1: rx = 27'($urandom & $urandom);
            2: rx = 27'($urandom | $urandom);
            default: rx = 27'($urandom) & (27'h7FFFFFF >> $urandom_range(0, 26));
         endcase
         model(rx, my, mc, ml);
         run_txn(rx, my, mc, ml, $urandom_range(0, 1), $urandom_range(0, 1), 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
